// File: rtl/gelato_warp_launcher.sv
// Warp launcher: splits a kernel launch into per-warp init packets, round-robin over cores.
// Optional perf counters (perf_warps, perf_stall) are built when GELATO_LAUNCH_PERF_EN is defined.
module gelato_warp_launcher #(
   parameter int ADDR_WIDTH = 32,
   parameter int WARP_SIZE  = 32,
   parameter int MAX_WARPS  = 16,
   parameter int NUM_CORES  = 4
) (
   input  logic                                               clk,
   input  logic                                               rst_n,
   input  logic                                               launch_valid,
   output logic                                               launch_ready,
   input  logic [ADDR_WIDTH-1:0]                              launch_pc,
   input  logic [31:0]                                        launch_workers,
   output logic                                               warp_valid,
   input  logic                                               warp_ready,
   output logic [ADDR_WIDTH-1:0]                              warp_pc,
   output logic [$clog2(MAX_WARPS)-1:0]                       warp_id,
   output logic [WARP_SIZE-1:0]                               warp_mask,
   output logic [(NUM_CORES > 1 ? $clog2(NUM_CORES) : 1)-1:0] warp_core,
   output logic                                               launch_done,
   output logic                                               launch_err,
`ifdef GELATO_LAUNCH_PERF_EN
   output logic [31:0]                                        perf_warps,
   output logic [31:0]                                        perf_stall,
`endif
   output logic [1:0]                                         dbg_state
);

   // Handshakes: a launch is taken when launch_valid && launch_ready; a warp packet
   // transfers when warp_valid && warp_ready, and warp_* stay stable until then.
   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_e;

   localparam int LOG_WS = $clog2(WARP_SIZE);
   localparam int ID_W   = $clog2(MAX_WARPS);
   localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam logic [63:0] WORKER_LIMIT = 64'(MAX_WARPS) * 64'(WARP_SIZE);
   localparam logic [CORE_W-1:0] LAST_CORE = CORE_W'(NUM_CORES - 1);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ID_W-1:0]       id_q, id_d;
   logic [ID_W-1:0]       last_id_q, last_id_d;
   logic [LOG_WS-1:0]     rem_q, rem_d;
   logic [CORE_W-1:0]     core_q, core_d;
   logic                  err_q, err_d;
   logic [31:0]           nwarps;
   logic                  over_limit;
   logic                  hs;

   assign nwarps     = (launch_workers >> LOG_WS) + {31'd0, |launch_workers[LOG_WS-1:0]};
   assign over_limit = {32'd0, launch_workers} > WORKER_LIMIT;
   assign hs         = warp_valid && warp_ready;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      id_d      = id_q;
      last_id_d = last_id_q;
      rem_d     = rem_q;
      core_d    = core_q;
      err_d     = err_q;
      unique case (state_q)
         IDLE: begin
            if (launch_valid) begin
               pc_d      = launch_pc;
               id_d      = '0;
               rem_d     = launch_workers[LOG_WS-1:0];
               last_id_d = ID_W'(nwarps - 32'd1);
               err_d     = 1'b0;
               if (over_limit) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else if (launch_workers == 32'd0) begin
                  state_d = DONE;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (warp_ready) begin
               // the core pointer is never cleared between launches
               core_d = (core_q == LAST_CORE) ? '0 : core_q + CORE_W'(1);
               if (id_q == last_id_q) state_d = DONE;
               else id_d = id_q + ID_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         id_q      <= '0;
         last_id_q <= '0;
         rem_q     <= '0;
         core_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         id_q      <= id_d;
         last_id_q <= last_id_d;
         rem_q     <= rem_d;
         core_q    <= core_d;
         err_q     <= err_d;
      end
   end

   assign launch_ready = (state_q == IDLE);
   assign warp_valid   = (state_q == ISSUE);
   assign launch_done  = (state_q == DONE);
   assign launch_err   = launch_done && err_q;
   assign warp_pc      = pc_q;
   assign warp_id      = id_q;
   assign warp_core    = core_q;
   assign dbg_state    = state_q;

   // Only the final warp can be partial; a zero remainder means it is full too.
   always_comb begin
      warp_mask = '0;
      if (warp_valid) begin
         warp_mask = '1;
         if (id_q == last_id_q && rem_q != '0) warp_mask = ~({WARP_SIZE{1'b1}} << rem_q);
      end
   end

`ifdef GELATO_LAUNCH_PERF_EN
   logic [31:0] perf_warps_q, perf_warps_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   always_comb begin
      perf_warps_d = perf_warps_q;
      perf_stall_d = perf_stall_q;
      if (hs) perf_warps_d = perf_warps_q + 32'd1;
      if (warp_valid && !warp_ready) perf_stall_d = perf_stall_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_warps_q <= '0;
         perf_stall_q <= '0;
      end else begin
         perf_warps_q <= perf_warps_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign perf_warps = perf_warps_q;
   assign perf_stall = perf_stall_q;
`else
   logic unused_hs;
   assign unused_hs = hs;
`endif

endmodule

// File: tb/tb_gelato_warp_launcher.sv
// Randomized bench for gelato_warp_launcher: per-launch expected packet queue built from
// ceil-division and mask rules, plus a free-running core counter model.
module tb_gelato_warp_launcher;

   localparam int AW   = 32;
   localparam int WS   = 32;
   localparam int MW   = 16;
   localparam int NC   = 4;
   localparam int IDW  = $clog2(MW);
   localparam int CW   = $clog2(NC);
   localparam int EW   = IDW + WS;

   logic          clk;
   logic          rst_n;
   logic          launch_valid;
   logic          launch_ready;
   logic [AW-1:0] launch_pc;
   logic [31:0]   launch_workers;
   logic          warp_valid;
   logic          warp_ready;
   logic [AW-1:0] warp_pc;
   logic [IDW-1:0] warp_id;
   logic [WS-1:0] warp_mask;
   logic [CW-1:0] warp_core;
   logic          launch_done;
   logic          launch_err;
   logic [1:0]    dbg_state;
`ifdef GELATO_LAUNCH_PERF_EN
   logic [31:0]   perf_warps;
   logic [31:0]   perf_stall;
`endif

   int total = 0;
   int bad   = 0;
   int model_core  = 0;
   int model_warps = 0;
   int model_stall = 0;
   logic [EW-1:0] exp_q[$];

   gelato_warp_launcher #(
      .ADDR_WIDTH(AW), .WARP_SIZE(WS), .MAX_WARPS(MW), .NUM_CORES(NC)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .launch_valid(launch_valid), .launch_ready(launch_ready),
      .launch_pc(launch_pc), .launch_workers(launch_workers),
      .warp_valid(warp_valid), .warp_ready(warp_ready),
      .warp_pc(warp_pc), .warp_id(warp_id), .warp_mask(warp_mask), .warp_core(warp_core),
      .launch_done(launch_done), .launch_err(launch_err),
`ifdef GELATO_LAUNCH_PERF_EN
      .perf_warps(perf_warps), .perf_stall(perf_stall),
`endif
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_perf(input string tag);
`ifdef GELATO_LAUNCH_PERF_EN
      check({tag, "_perf_warps"}, perf_warps, model_warps);
      check({tag, "_perf_stall"}, perf_stall, model_stall);
`else
      total = total + 0;
`endif
   endtask

   // driver: one full launch, entered and left on a negedge with the DUT idle
   task automatic run_launch(input logic [AW-1:0] pc, input logic [31:0] w,
                             input int stall_pct, input int fixed_stall, input bit junk);
      bit err;
      longint nw;
      int rem;
      int st;
      int cyc;
      bit done_seen;
      logic [WS-1:0] m;
      logic [EW-1:0] e;
      exp_q.delete();
      err = (64'(w) > 64'(MW) * 64'(WS));
      nw  = err ? 0 : (longint'(w) + WS - 1) / WS;
      rem = int'(w % WS);
      for (longint k = 0; k < nw; k++) begin
         m = '1;
         if (k == nw - 1 && rem != 0) begin
            m = '0;
            for (int j = 0; j < rem; j++) m[j] = 1'b1;
         end
         exp_q.push_back({IDW'(k), m});
      end

      check("ready_idle", launch_ready, 1);
      launch_valid   = 1'b1;
      launch_pc      = pc;
      launch_workers = w;
      warp_ready     = 1'b0;
      @(negedge clk);
      launch_valid = junk;
      if (junk) begin
         launch_pc      = $urandom;
         launch_workers = $urandom;
      end
      done_seen = 0;
      cyc = 0;
      st = 0;
      while (!done_seen && cyc < 2000) begin
         check("warp_valid", warp_valid, exp_q.size() != 0);
         check("ready_busy", launch_ready, 0);
         if (exp_q.size() != 0) begin
            e = exp_q[0];
            check("warp_id", warp_id, e[EW-1:WS]);
            check("warp_mask", warp_mask, e[WS-1:0]);
            check("warp_core", warp_core, model_core);
            check("warp_pc", warp_pc, pc);
            check("done_early", launch_done, 0);
            check("err_no_done", launch_err, 0);
            if (st < fixed_stall) begin
               warp_ready = 1'b0;
               st++;
            end else begin
               warp_ready = ($urandom_range(0, 99) >= stall_pct);
            end
            if (warp_ready) begin
               void'(exp_q.pop_front());
               model_core = (model_core + 1) % NC;
               model_warps++;
            end else begin
               model_stall++;
            end
         end else begin
            check("launch_done", launch_done, 1);
            check("launch_err", launch_err, err);
            done_seen    = 1;
            warp_ready   = 1'b0;
            launch_valid = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      if (!done_seen) check("timeout", 0, 1);
      check("done_pulse", launch_done, 0);
      check("err_after", launch_err, 0);
      check("valid_after", warp_valid, 0);
      check_perf("launch");
   endtask

   // driver: reset in the middle of a 4-warp launch
   task automatic mid_reset();
      launch_valid   = 1'b1;
      launch_pc      = 32'hC0DE_0000;
      launch_workers = 32'd128;
      warp_ready     = 1'b1;
      @(negedge clk);
      launch_valid = 1'b0;
      check("mr_core0", warp_core, model_core);
      @(negedge clk);
      @(negedge clk);
      check("mr_id2", warp_id, 2);
      rst_n = 1'b0;
      #1;
      check("mr_valid", warp_valid, 0);
      check("mr_ready", launch_ready, 1);
      check("mr_done", launch_done, 0);
      check("mr_core", warp_core, 0);
      check("mr_mask", warp_mask, 0);
      model_core  = 0;
      model_warps = 0;
      model_stall = 0;
      warp_ready  = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("mr_no_done", launch_done, 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("mr_no_done_post", launch_done, 0);
      check_perf("mr");
   endtask

   initial begin
      logic [31:0] w;
      rst_n          = 1'b0;
      launch_valid   = 1'b0;
      launch_pc      = '0;
      launch_workers = '0;
      warp_ready     = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", launch_ready, 1);
      check("rst_valid", warp_valid, 0);
      check("rst_id", warp_id, 0);
      check("rst_mask", warp_mask, 0);
      check("rst_core", warp_core, 0);
      check("rst_pc", warp_pc, 0);
      check("rst_done", launch_done, 0);
      check("rst_err", launch_err, 0);
      rst_n = 1'b1;
      @(negedge clk);

      run_launch(32'h0000_1000, 32'd70, 0, 0, 0);
      run_launch(32'h0000_2000, 32'd0, 0, 0, 0);
      run_launch(32'h0000_3000, 32'd513, 0, 0, 0);
      run_launch(32'h0000_4000, 32'd64, 0, 5, 0);
      run_launch(32'h0000_5000, 32'd96, 0, 0, 0);
      run_launch(32'h0000_6000, 32'd96, 0, 0, 0);
      run_launch(32'h0000_7000, 32'd512, 20, 0, 1);
      run_launch(32'h0000_8000, 32'd1, 0, 0, 0);
      run_launch(32'h0000_9000, 32'hFFFF_FFFF, 0, 0, 1);
      mid_reset();
      run_launch(32'h0000_A000, 32'd70, 0, 0, 0);

      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 4))
            0:       w = 32'd0;
            1:       w = 32'd513 + $urandom_range(0, 10000);
            2:       w = $urandom;
            3:       w = 32'(WS * $urandom_range(1, MW));
            default: w = $urandom_range(1, MW * WS);
         endcase
         run_launch($urandom, w, $urandom_range(0, 60), 0, 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
